// File: rtl/tic_tac_toe_turn_scheduler.sv
// tic_tac_toe_turn_scheduler: turn scheduler and handshake front end for the tic-tac-toe game core.
//   Alternates player/computer moves (player first), strobes accepted moves into the core,
//   reads back the core status and keeps round result, move count and scores.
//   Optional feature macro TURN_TIMEOUT_EN: computer forfeits after TIMEOUT_CYCLES silent cycles.
// Ports:
//   clock, reset (async, active-low), start
//   pl_valid/pl_pos/pl_ready, pc_valid/pc_pos/pc_ready   move request handshakes
//   clr_board, play, pc, player_position, computer_position   game core controls
//   illegal_move, win, no_space, who                      game core status
//   move_reject, round_done, result, move_cnt, pl_score, pc_score, timeout_flag
module tic_tac_toe_turn_scheduler #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int SCORE_W        = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               pl_valid,
    input  logic [3:0]         pl_pos,
    output logic               pl_ready,
    input  logic               pc_valid,
    input  logic [3:0]         pc_pos,
    output logic               pc_ready,
    output logic               clr_board,
    output logic               play,
    output logic               pc,
    output logic [3:0]         player_position,
    output logic [3:0]         computer_position,
    input  logic               illegal_move,
    input  logic               win,
    input  logic               no_space,
    input  logic [1:0]         who,
    output logic               move_reject,
    output logic               round_done,
    output logic [1:0]         result,
    output logic [3:0]         move_cnt,
    output logic [SCORE_W-1:0] pl_score,
    output logic [SCORE_W-1:0] pc_score,
    output logic               timeout_flag
);
    typedef enum logic [3:0] {
        IDLE, CLEAR, WAIT_PL, ISSUE_PL, CHECK_PL, WAIT_PC, ISSUE_PC, CHECK_PC, DONE
    } state_t;

    state_t state;
    logic   timed_out;

    assign pl_ready   = state == WAIT_PL;
    assign pc_ready   = state == WAIT_PC;
    assign clr_board  = state == CLEAR;
    assign play       = state == ISSUE_PL;
    assign pc         = state == ISSUE_PC;
    assign round_done = state == DONE;

`ifdef TURN_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] to_cnt;

    // Counts cycles spent in WAIT_PC; zero on every entry. A refused (out-of-range)
    // request still lets the count advance, so the forfeit lands on the next silent cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            to_cnt <= '0;
        else if (state != WAIT_PC)
            to_cnt <= '0;
        else if (to_cnt != '1)
            to_cnt <= to_cnt + 16'd1;
    end

    // An accept in the limit cycle takes priority over the forfeit.
    assign timed_out = state == WAIT_PC && !pc_valid && to_cnt >= TO_LAST;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            player_position   <= '0;
            computer_position <= '0;
            move_reject       <= 1'b0;
            result            <= '0;
            move_cnt          <= '0;
            pl_score          <= '0;
            pc_score          <= '0;
            timeout_flag      <= 1'b0;
        end else begin
            move_reject <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    // Round bookkeeping is zeroed on the way into CLEAR so it already reads 0 there.
                    if (start) begin
                        state        <= CLEAR;
                        move_cnt     <= '0;
                        result       <= '0;
                        timeout_flag <= 1'b0;
                    end
                end
                CLEAR: state <= WAIT_PL;
                WAIT_PL: begin
                    if (pl_valid) begin
                        if (pl_pos > 4'd8) begin
                            move_reject <= 1'b1;
                        end else begin
                            player_position <= pl_pos;
                            state           <= ISSUE_PL;
                        end
                    end
                end
                WAIT_PC: begin
                    if (pc_valid) begin
                        if (pc_pos > 4'd8) begin
                            move_reject <= 1'b1;
                        end else begin
                            computer_position <= pc_pos;
                            state             <= ISSUE_PC;
                        end
                    end else if (timed_out) begin
                        result       <= 2'b01;
                        timeout_flag <= 1'b1;
                        state        <= DONE;
                        if (pl_score != '1)
                            pl_score <= pl_score + 1'b1;
                    end
                end
                ISSUE_PL: state <= CHECK_PL;
                ISSUE_PC: state <= CHECK_PC;
                CHECK_PL, CHECK_PC: begin
                    if (illegal_move) begin
                        move_reject <= 1'b1;
                        state       <= (state == CHECK_PL) ? WAIT_PL : WAIT_PC;
                    end else begin
                        move_cnt <= move_cnt + 4'd1;
                        if (win) begin
                            result <= who;
                            state  <= DONE;
                            if (who == 2'b01 && pl_score != '1)
                                pl_score <= pl_score + 1'b1;
                            if (who == 2'b10 && pc_score != '1)
                                pc_score <= pc_score + 1'b1;
                        end else if (no_space) begin
                            result <= 2'b11;
                            state  <= DONE;
                        end else begin
                            state <= (state == CHECK_PL) ? WAIT_PC : WAIT_PL;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tic_tac_toe_turn_scheduler.sv
// tb_tic_tac_toe_turn_scheduler: self-checking bench; a scripted game model predicts every output each cycle.
module tb_tic_tac_toe_turn_scheduler;
    localparam int TO = 4;
    localparam int SW = 3;

    logic clock = 0, reset = 0, start = 0, pl_valid = 0, pc_valid = 0;
    logic [3:0] pl_pos = 0, pc_pos = 0;
    logic illegal_move = 0, win = 0, no_space = 0;
    logic [1:0] who = 0;
    logic pl_ready, pc_ready, clr_board, play, pc, move_reject, round_done, timeout_flag;
    logic [3:0] player_position, computer_position, move_cnt;
    logic [1:0] result;
    logic [SW-1:0] pl_score, pc_score;

    logic e_pl_ready = 0, e_pc_ready = 0, e_clr = 0, e_play = 0, e_pc = 0, e_rej = 0, e_done = 0, e_to = 0;
    logic [3:0] e_ppos = 0, e_cpos = 0, e_cnt = 0;
    logic [1:0] e_result = 0;
    logic [SW-1:0] e_pls = 0, e_pcs = 0;
    int pc_wait = 0;
    int n_cmp = 0, n_bad = 0;

    tic_tac_toe_turn_scheduler #(.TIMEOUT_CYCLES(TO), .SCORE_W(SW)) dut (
        .clock(clock), .reset(reset), .start(start),
        .pl_valid(pl_valid), .pl_pos(pl_pos), .pl_ready(pl_ready),
        .pc_valid(pc_valid), .pc_pos(pc_pos), .pc_ready(pc_ready),
        .clr_board(clr_board), .play(play), .pc(pc),
        .player_position(player_position), .computer_position(computer_position),
        .illegal_move(illegal_move), .win(win), .no_space(no_space), .who(who),
        .move_reject(move_reject), .round_done(round_done), .result(result),
        .move_cnt(move_cnt), .pl_score(pl_score), .pc_score(pc_score),
        .timeout_flag(timeout_flag)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        check("pl_ready", 16'(pl_ready), 16'(e_pl_ready));
        check("pc_ready", 16'(pc_ready), 16'(e_pc_ready));
        check("clr_board", 16'(clr_board), 16'(e_clr));
        check("play", 16'(play), 16'(e_play));
        check("pc", 16'(pc), 16'(e_pc));
        check("player_position", 16'(player_position), 16'(e_ppos));
        check("computer_position", 16'(computer_position), 16'(e_cpos));
        check("move_reject", 16'(move_reject), 16'(e_rej));
        check("round_done", 16'(round_done), 16'(e_done));
        check("result", 16'(result), 16'(e_result));
        check("move_cnt", 16'(move_cnt), 16'(e_cnt));
        check("pl_score", 16'(pl_score), 16'(e_pls));
        check("pc_score", 16'(pc_score), 16'(e_pcs));
        check("timeout_flag", 16'(timeout_flag), 16'(e_to));
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1);
    end

    function automatic logic [SW-1:0] inc(input logic [SW-1:0] v);
        return (v == {SW{1'b1}}) ? v : v + 1'b1;
    endfunction

    task automatic model_reset();
        {e_pl_ready, e_pc_ready, e_clr, e_play, e_pc, e_rej, e_done, e_to} = '0;
        e_ppos = 0; e_cpos = 0; e_cnt = 0; e_result = 0; e_pls = 0; e_pcs = 0;
    endtask

    // Advance to just after the next rising edge; one-cycle pulses default to low.
    task automatic step();
        @(posedge clock);
        #1;
        e_clr = 0; e_play = 0; e_pc = 0; e_rej = 0;
    endtask

    task automatic idle_inputs();
        start = 0; pl_valid = 0; pc_valid = 0;
        illegal_move = 0; win = 0; no_space = 0; who = 0;
    endtask

    // Random noise the DUT must ignore: the idle side's request, status lines, start.
    task automatic junk(input bit side);
        if (side) begin pl_valid = 1'($urandom); pl_pos = 4'($urandom); end
        else begin pc_valid = 1'($urandom); pc_pos = 4'($urandom); end
        illegal_move = 1'($urandom); win = 1'($urandom); no_space = 1'($urandom); who = 2'($urandom);
        start = $urandom_range(0, 5) == 0;
    endtask

    task automatic start_round();
        idle_inputs();
        start = 1;
        step();
        start = 0;
        e_clr = 1; e_done = 0; e_result = 0; e_cnt = 0; e_to = 0; e_pl_ready = 0; e_pc_ready = 0;
        check("clr_pulse", 16'(clr_board), 16'd1);
        step();
        e_pl_ready = 1;
        pc_wait = 0;
    endtask

    // One request from side (0 player, 1 computer) after delay silent cycles.
    // oc: 0 = still the same side's turn, 1 = turn passed, 2 = round over.
    task automatic turn(input bit side, input int delay, input logic [3:0] pos,
                        input logic ill, input logic w, input logic nsp, input logic [1:0] wh,
                        output int oc);
        oc = 0;
        for (int i = 0; i < delay; i++) begin
            junk(side);
            if (side) pc_valid = 0; else pl_valid = 0;
`ifdef TURN_TIMEOUT_EN
            if (side && pc_wait >= TO - 1) begin
                step();
                idle_inputs();
                e_pc_ready = 0; e_done = 1; e_result = 2'b01; e_to = 1; e_pls = inc(e_pls);
                oc = 2;
                return;
            end
`endif
            step();
            if (side) pc_wait++;
        end
        junk(side);
        if (side) begin pc_valid = 1; pc_pos = pos; end else begin pl_valid = 1; pl_pos = pos; end
        step();
        junk(side);
        if (side) pc_valid = 0; else pl_valid = 0;
        if (pos > 8) begin
            e_rej = 1;
            if (side) pc_wait++;
            idle_inputs();
            return;
        end
        if (side) begin e_cpos = pos; e_pc = 1; e_pc_ready = 0; end
        else begin e_ppos = pos; e_play = 1; e_pl_ready = 0; end
        step();
        junk(side);
        illegal_move = ill; win = w; no_space = nsp; who = wh;
        step();
        idle_inputs();
        if (ill) begin
            e_rej = 1;
            if (side) begin e_pc_ready = 1; pc_wait = 0; end else e_pl_ready = 1;
        end else begin
            e_cnt++;
            if (w) begin
                e_result = wh; e_done = 1; oc = 2;
                if (wh == 2'b01) e_pls = inc(e_pls);
                if (wh == 2'b10) e_pcs = inc(e_pcs);
            end else if (nsp) begin
                e_result = 2'b11; e_done = 1; oc = 2;
            end else begin
                oc = 1;
                if (side) e_pl_ready = 1; else begin e_pc_ready = 1; pc_wait = 0; end
            end
        end
    endtask

    task automatic random_round();
        int oc;
        bit side;
        logic [3:0] pos;
        logic ill, w, n;
        start_round();
        side = 0;
        do begin
            pos = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            ill = $urandom_range(0, 6) == 0;
            w = e_cnt >= 4 && $urandom_range(0, 3) == 0;
            n = e_cnt == 8 || (e_cnt >= 5 && $urandom_range(0, 5) == 0);
            turn(side, side ? $urandom_range(0, 5) : $urandom_range(0, 3), pos, ill, w, n,
                 $urandom_range(0, 1) ? 2'b01 : 2'b10, oc);
            if (oc == 1) side = ~side;
        end while (oc != 2);
        repeat ($urandom_range(0, 2)) begin
            pl_valid = 1'($urandom); pc_valid = 1'($urandom);
            step();
        end
        idle_inputs();
    endtask

    initial begin
        int oc;
        model_reset();
        repeat (3) step();
        check("rst_outputs", 16'({pl_ready, pc_ready, round_done, result, move_cnt}), 16'd0);
        reset = 1;
        pl_valid = 1; pc_valid = 1; pl_pos = 2; pc_pos = 3;
        repeat (3) step();
        check("idle_ignores_valid", 16'({pl_ready, pc_ready, player_position}), 16'd0);
        idle_inputs();

        start_round();
        check("ready_after_clear", 16'(pl_ready), 16'd1);
        turn(0, 0, 4'd4, 0, 0, 0, 2'b00, oc);
        check("first_ppos", 16'(player_position), 16'd4);
        check("first_cnt", 16'(move_cnt), 16'd1);
        check("first_pc_ready", 16'(pc_ready), 16'd1);
        turn(1, 1, 4'd0, 0, 1, 0, 2'b10, oc);
        check("r1_pc_score", 16'(pc_score), 16'd1);

        start_round();
        turn(0, 0, 4'd0, 0, 0, 0, 2'b00, oc);
        turn(1, 0, 4'd3, 0, 0, 0, 2'b00, oc);
        turn(0, 2, 4'd1, 0, 0, 0, 2'b00, oc);
        turn(1, 0, 4'd4, 0, 0, 0, 2'b00, oc);
        turn(0, 0, 4'd2, 0, 1, 0, 2'b01, oc);
        check("r2_result", 16'(result), 16'd1);
        check("r2_pl_score", 16'(pl_score), 16'd1);
        check("r2_cnt", 16'(move_cnt), 16'd5);
        check("r2_done", 16'(round_done), 16'd1);

        start_round();
        turn(0, 1, 4'd12, 0, 0, 0, 2'b00, oc);
        check("oor_reject", 16'({move_reject, pl_ready, play}), 16'b110);
        turn(0, 0, 4'd0, 1, 0, 0, 2'b00, oc);
        check("illegal_reject", 16'({move_reject, pl_ready, move_cnt}), 16'h30);
        for (int k = 0; k < 9; k++) begin
            turn(k[0], 0, 4'(k), 0, 0, k == 8, 2'b00, oc);
        end
        check("draw_result", 16'(result), 16'd3);
        check("draw_cnt", 16'(move_cnt), 16'd9);
        check("draw_scores", 16'({pl_score, pc_score}), 16'({3'd1, 3'd1}));

        start_round();
        turn(0, 0, 4'd0, 0, 1, 1, 2'b10, oc);
        check("win_over_draw", 16'(result), 16'd2);
        check("win_over_draw_score", 16'(pc_score), 16'd2);

`ifdef TURN_TIMEOUT_EN
        start_round();
        turn(0, 0, 4'd0, 0, 0, 0, 2'b00, oc);
        turn(1, 10, 4'd1, 0, 0, 0, 2'b00, oc);
        check("timeout_result", 16'({result, timeout_flag, round_done}), 16'b0111);
        check("timeout_score", 16'(pl_score), 16'd2);
        start_round();
        turn(0, 0, 4'd0, 0, 0, 0, 2'b00, oc);
        turn(1, TO - 1, 4'd1, 0, 0, 0, 2'b00, oc);
        check("accept_at_limit", 16'(oc), 16'd1);
        turn(0, 0, 4'd2, 0, 1, 0, 2'b01, oc);
`endif

        repeat (40) random_round();

        start_round();
        turn(0, 0, 4'd5, 0, 0, 0, 2'b00, oc);
        pc_valid = 1; pc_pos = 4'd6;
        step();
        pc_valid = 0;
        reset = 0;
        model_reset();
        #1;
        check("async_rst_pc", 16'(pc), 16'd0);
        check("async_rst_regs", 16'({computer_position, player_position, pl_score, pc_score}), 16'd0);
        repeat (2) step();
        reset = 1;
        pl_valid = 1; pl_pos = 4'd1;
        repeat (3) step();
        check("no_ready_before_start", 16'(pl_ready), 16'd0);
        idle_inputs();
        start_round();
        check("ready_after_start", 16'(pl_ready), 16'd1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
